// File: rtl/dmem_target_if.sv
// Valid/ready request and one-cycle response bus between the CPU data port
// and dmem_target.
interface dmem_target_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  we;
    logic        rsp_valid;
    logic [31:0] drdata;
    logic        rsp_err;

    modport master (
        output req_valid, daddr, dwdata, we,
        input  req_ready, rsp_valid, drdata, rsp_err
    );

    modport slave (
        input  req_valid, daddr, dwdata, we,
        output req_ready, rsp_valid, drdata, rsp_err
    );
endinterface

// File: rtl/dmem_target.sv
// Multi-cycle data-memory responder with fixed wait states and byte-lane writes.
// Optional MMIO cycle counter / scratch register enabled by DMEM_TARGET_MMIO_EN.
module dmem_target #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    dmem_target_if.slave bus
);
    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Read (all-zero enables) or a naturally aligned byte/half/word store.
    function automatic logic we_legal(input logic [3:0] we, input logic [1:0] off);
        logic ok;
        case (we)
            4'b0000: ok = 1'b1;
            4'b0001: ok = (off == 2'd0);
            4'b0010: ok = (off == 2'd1);
            4'b0100: ok = (off == 2'd2);
            4'b1000: ok = (off == 2'd3);
            4'b0011: ok = (off == 2'd0);
            4'b1100: ok = (off == 2'd2);
            4'b1111: ok = (off == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  we_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] drdata_q;
    logic        rsp_err_q;

    logic        accept_s;
    logic        commit_s;
    logic [31:0] c_addr_s;
    logic [31:0] c_wdata_s;
    logic [3:0]  c_we_s;
    logic        is_write_s;
    logic        in_ram_s;
    logic        is_cnt_s;
    logic        is_scr_s;
    logic        err_s;
    logic        ram_we_s;
    logic [AW-1:0] ram_idx_s;
    logic [31:0] rd_data_s;
    logic [31:0] mmio_rdata_s;

    logic [31:0] mem_q [DEPTH_WORDS];

    // Next-state logic: accept in IDLE, count down in WAIT, one response cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        commit_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = RESP;
                        commit_s = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = RESP;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the commit edge is the accept edge, so use the live bus.
    always_comb begin
        if (state_q == IDLE) begin
            c_addr_s  = bus.daddr;
            c_wdata_s = bus.dwdata;
            c_we_s    = bus.we;
        end else begin
            c_addr_s  = addr_q;
            c_wdata_s = wdata_q;
            c_we_s    = we_q;
        end
    end

    assign is_write_s = (c_we_s != 4'b0000);
    assign in_ram_s   = (c_addr_s[31:2] < 30'(DEPTH_WORDS));
    assign ram_idx_s  = c_addr_s[AW+1:2];

    // Error decode: bad lane pattern, unmapped address, or store to the counter.
    always_comb begin
        if (!we_legal(c_we_s, c_addr_s[1:0])) begin
            err_s = 1'b1;
        end else if (!(in_ram_s || is_cnt_s || is_scr_s)) begin
            err_s = 1'b1;
        end else if (is_cnt_s && is_write_s) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    assign ram_we_s  = commit_s && !reset && !err_s && is_write_s && in_ram_s;
    assign rd_data_s = in_ram_s ? mem_q[ram_idx_s] : mmio_rdata_s;

`ifdef DMEM_TARGET_MMIO_EN
    localparam logic [29:0] CNT_WORD = 30'h3FFF_FFFC;
    localparam logic [29:0] SCR_WORD = 30'h3FFF_FFFD;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  we);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = we[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return m;
    endfunction

    logic [31:0] cyc_q;
    logic [31:0] scr_q;

    assign is_cnt_s     = (c_addr_s[31:2] == CNT_WORD);
    assign is_scr_s     = (c_addr_s[31:2] == SCR_WORD);
    assign mmio_rdata_s = is_cnt_s ? cyc_q : scr_q;

    // Free-running cycle counter and lane-writable scratch register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= 32'd0;
            scr_q <= 32'd0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (commit_s && !err_s && is_write_s && is_scr_s) begin
                scr_q <= merge_lanes(scr_q, c_wdata_s, c_we_s);
            end else begin
                scr_q <= scr_q;
            end
        end
    end
`else
    assign is_cnt_s     = 1'b0;
    assign is_scr_s     = 1'b0;
    assign mmio_rdata_s = 32'd0;
`endif

    // Control, capture and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            we_q        <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            drdata_q    <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            if (accept_s) begin
                addr_q  <= bus.daddr;
                wdata_q <= bus.dwdata;
                we_q    <= bus.we;
            end
            if (commit_s) begin
                rsp_err_q <= err_s;
                drdata_q  <= (err_s || is_write_s) ? 32'd0 : rd_data_s;
            end
        end
    end

    // RAM byte-lane write; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (c_we_s[i]) begin
                    mem_q[ram_idx_s][8*i +: 8] <= c_wdata_s[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.drdata    = drdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_target.sv
// Self-checking bench for dmem_target: directed vector table, reset and
// handshake sequences, and randomized traffic against a word-array model.
module tb_dmem_target;
    localparam int W2    = 2;
    localparam int DEPTH = 1024;
`ifdef DMEM_TARGET_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic clk;
    logic rst2;
    logic rst0;
    int   tb_cyc;
    int   n_checks;
    int   n_fail;

    dmem_target_if b2 ();
    dmem_target_if b0 ();

    dmem_target #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W2)) dut (
        .clk(clk), .reset(rst2), .bus(b2.slave));
    dmem_target #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst0), .bus(b0.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vecs [20];
    int   n_vecs;

    logic [31:0] model_mem [32];
    logic [31:0] model_scr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Legal iff the mask is a contiguous run of 1, 2 or 4 lanes aligned to its size.
    function automatic bit legal_pattern(input logic [3:0] w, input logic [1:0] off);
        int n;
        if (w == 4'd0) return 1'b1;
        n = $countones(w);
        if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
        if ((int'(off) % n) != 0) return 1'b0;
        return (w == 4'(((1 << n) - 1) << off));
    endfunction

    function automatic logic [31:0] apply_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] w);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // One transaction on the WAIT_CYCLES=2 instance; entered and left on a negedge.
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] w,
                          output logic [31:0] rd, output logic er, output int t_acc);
        int guard;
        int n;
        guard = 0;
        while (!b2.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 32'd0, 32'd1);
        b2.req_valid = 1'b1;
        b2.daddr     = a;
        b2.dwdata    = wd;
        b2.we        = w;
        t_acc        = tb_cyc + 1;
        @(negedge clk);
        b2.req_valid = 1'b0;
        n = 1;
        while (!b2.rsp_valid && n < 50) begin
            check("ready_low_busy", {31'd0, b2.req_ready}, 32'd0);
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("rsp_timeout", 32'd0, 32'd1);
        check("latency", n, W2 + 1);
        check("ready_low_resp", {31'd0, b2.req_ready}, 32'd0);
        rd = b2.drdata;
        er = b2.rsp_err;
        @(negedge clk);
        check("rsp_one_cycle", {31'd0, b2.rsp_valid}, 32'd0);
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] w,
                           input logic [31:0] ed, input logic ee);
        vecs[n_vecs] = '{addr: a, wdata: wd, we: w, exp_d: ed, exp_e: ee};
        n_vecs++;
    endtask

    initial begin
        logic [31:0] rd, rd1, wd, a, e_d;
        logic        er, er1, e_e;
        logic [3:0]  w;
        int          t0, t1, kind, idx, sz;
        logic [1:0]  off;

        n_checks = 0;
        n_fail   = 0;
        tb_cyc   = 0;
        n_vecs   = 0;
        rst2 = 1'b1;
        rst0 = 1'b1;
        b2.req_valid = 1'b0; b2.daddr = 32'd0; b2.dwdata = 32'd0; b2.we = 4'd0;
        b0.req_valid = 1'b0; b0.daddr = 32'd0; b0.dwdata = 32'd0; b0.we = 4'd0;
        repeat (3) @(negedge clk);
        rst2 = 1'b0;
        rst0 = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, b2.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, b2.rsp_valid}, 32'd0);
        check("rst_drdata", b2.drdata, 32'd0);
        check("rst_err", {31'd0, b2.rsp_err}, 32'd0);
        check("rst0_ready", {31'd0, b0.req_ready}, 32'd1);

        add_vec(32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
        add_vec(32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);
        add_vec(32'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0);
        add_vec(32'h21, 32'hAAAAAAAA, 4'b0010, 32'h0, 1'b0);
        add_vec(32'h20, 32'h0, 4'b0000, 32'h1122AA44, 1'b0);
        add_vec(32'h22, 32'hBEEFBEEF, 4'b1100, 32'h0, 1'b0);
        add_vec(32'h23, 32'h0, 4'b0000, 32'hBEEFAA44, 1'b0);
        add_vec(32'h21, 32'hFFFFFFFF, 4'b0110, 32'h0, 1'b1);
        add_vec(32'h21, 32'hFFFFFFFF, 4'b0011, 32'h0, 1'b1);
        add_vec(32'h20, 32'h0, 4'b0000, 32'hBEEFAA44, 1'b0);
        add_vec(32'h23, 32'h11111111, 4'b1000, 32'h0, 1'b0);
        add_vec(32'h20, 32'h0, 4'b0000, 32'h11EFAA44, 1'b0);
        add_vec(32'h1000, 32'h0, 4'b0000, 32'h0, 1'b1);
        add_vec(32'h1000, 32'h12345678, 4'b1111, 32'h0, 1'b1);
        add_vec(32'hFFC, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0);
        add_vec(32'hFFC, 32'h0, 4'b0000, 32'h0BADF00D, 1'b0);
        add_vec(32'h30, 32'h0, 4'b1111, 32'h0, 1'b0);
        add_vec(32'hFFFFFFF4, 32'h5A5A5A5A, 4'b0001, 32'h0, !MMIO);
        add_vec(32'hFFFFFFF4, 32'h0, 4'b0000, MMIO ? 32'h5A : 32'h0, !MMIO);
        add_vec(32'hFFFFFFF0, 32'h1, 4'b1111, 32'h0, 1'b1);

        for (int i = 0; i < n_vecs; i++) begin
            do_req(vecs[i].addr, vecs[i].wdata, vecs[i].we, rd, er, t0);
            check($sformatf("vec%0d_data", i), rd, vecs[i].exp_d);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_e});
        end

        // Reset lands on the commit edge of a write to 0x30.
        b2.req_valid = 1'b1; b2.daddr = 32'h30; b2.dwdata = 32'hCAFEF00D; b2.we = 4'b1111;
        @(negedge clk);
        b2.req_valid = 1'b0;
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        check("midrst_rsp_valid", {31'd0, b2.rsp_valid}, 32'd0);
        check("midrst_ready", {31'd0, b2.req_ready}, 32'd1);
        check("midrst_drdata", b2.drdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", {31'd0, b2.rsp_valid}, 32'd0);
        end
        do_req(32'h30, 32'h0, 4'b0000, rd, er, t0);
        check("midrst_mem", rd, 32'h0);
        check("midrst_err", {31'd0, er}, 32'd0);

        // Counter reads accepted exactly 10 cycles apart.
        do_req(32'hFFFFFFF0, 32'h0, 4'b0000, rd, er, t0);
        while (tb_cyc + 1 < t0 + 10) @(negedge clk);
        do_req(32'hFFFFFFF0, 32'h0, 4'b0000, rd1, er1, t1);
        check("cnt_gap", t1 - t0, 32'd10);
        check("cnt_err", {30'd0, er, er1}, MMIO ? 32'd0 : 32'd3);
        check("cnt_diff", rd1 - rd, MMIO ? 32'd10 : 32'd0);

        // Zero-wait instance with req_valid held high: accept on every other edge.
        b0.req_valid = 1'b1; b0.daddr = 32'h1000; b0.we = 4'b0000;
        for (int k = 0; k < 20; k++) begin
            check("hs_ready", {31'd0, b0.req_ready}, {31'd0, (k % 2) == 0});
            check("hs_rsp", {31'd0, b0.rsp_valid}, {31'd0, (k % 2) == 1});
            if (b0.rsp_valid) check("hs_err", {31'd0, b0.rsp_err}, 32'd1);
            @(negedge clk);
        end
        b0.req_valid = 1'b0;

        // Randomized traffic against the model, after seeding words 0..31.
        for (int i = 0; i < 32; i++) begin
            model_mem[i] = $urandom;
            do_req(32'(i * 4), model_mem[i], 4'b1111, rd, er, t0);
        end
        model_scr = 32'd0;
        if (MMIO) do_req(32'hFFFFFFF4, 32'h0, 4'b1111, rd, er, t0);
        for (int k = 0; k < 200; k++) begin
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, 31);
            off  = 2'($urandom_range(0, 3));
            wd   = $urandom;
            a    = 32'(idx * 4) | {30'd0, off};
            if (kind <= 3) begin
                sz = (kind == 0) ? 4 : (kind == 1) ? 2 : 1;
                w  = 4'(((1 << sz) - 1) << off);
            end else if (kind == 4) begin
                w = 4'($urandom_range(1, 15));
            end else if (kind == 8) begin
                a = {30'($urandom_range(32'h3FFFFFFB, DEPTH)), off};
                w = 4'($urandom_range(0, 15));
            end else if (kind == 9) begin
                a = 32'hFFFFFFF4 | {30'd0, off};
                w = 4'($urandom_range(0, 15));
            end else begin
                w = 4'd0;
            end
            e_d = 32'd0;
            e_e = 1'b1;
            if (legal_pattern(w, a[1:0])) begin
                if (kind <= 7) begin
                    e_e = 1'b0;
                    if (w == 4'd0) e_d = model_mem[idx];
                    else model_mem[idx] = apply_lanes(model_mem[idx], wd, w);
                end else if (kind == 9 && MMIO) begin
                    e_e = 1'b0;
                    if (w == 4'd0) e_d = model_scr;
                    else model_scr = apply_lanes(model_scr, wd, w);
                end
            end
            do_req(a, wd, w, rd, er, t0);
            check($sformatf("rnd%0d_data a=%08h we=%b", k, a, w), rd, e_d);
            check($sformatf("rnd%0d_err a=%08h we=%b", k, a, w), {31'd0, er}, {31'd0, e_e});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
